// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (types only).
// Backpressure: n/a.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of a counter that must hold 0..value-1 (never less than one bit).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < value) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of D from the shifted partial remainder.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_r_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r_next,
  output logic             o_carry
);

  logic [WIDTH:0]   w_d_inv;
  logic [WIDTH+1:0] w_sum;

  // Subtraction built as an add of the inverted operand with carry-in of one;
  // the carry-out is the no-borrow flag (R_shifted >= D) and doubles as the
  // quotient bit for this step.
  assign w_d_inv  = ~{1'b0, i_d};
  assign w_sum    = {1'b0, i_r_shift} + {1'b0, w_d_inv} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign o_carry  = w_sum[WIDTH+1];

  // Restore (keep the shifted remainder) when the trial subtract borrowed.
  assign o_r_next = o_carry ? w_sum[WIDTH:0] : i_r_shift;

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one shift/trial-subtract per clock.
// Latency: WIDTH cycles from accepted start to done (1 cycle for divide by zero).
// Backpressure: start is accepted only in IDLE; requests while busy/done are dropped.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int              CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH:0]   w_r_next;
  logic             w_carry;
  logic [WIDTH-1:0] w_q_next;

  // {R,Q} shifted left by one: the MSB of R falls off, Q's MSB enters R.
  assign w_r_shift = (r_r << 1) | {{WIDTH{1'b0}}, r_q[WIDTH-1]};
  assign w_q_next  = {r_q[WIDTH-2:0], w_carry};

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_r_shift(w_r_shift),
    .i_d      (r_d),
    .o_r_next (w_r_next),
    .o_carry  (w_carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a zero divisor skips RUN and reports immediately.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = (i_divisor == '0) ? DONE : RUN;
      RUN:     if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r           <= '0;
      r_q           <= '0;
      r_d           <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_divisor == '0) begin
              r_quotient    <= '1;
              r_remainder   <= i_dividend;
              r_div_by_zero <= 1'b1;
            end else begin
              r_d   <= i_divisor;
              r_q   <= i_dividend;
              r_r   <= '0;
              r_cnt <= '0;
            end
          end
        end
        RUN: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_quotient    <= w_q_next;
            r_remainder   <= w_r_next[WIDTH-1:0];
            r_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor checks them.
// Latency: expects WIDTH edges from accept to done, zero edges for divide by zero.
// Backpressure: stimulus waits for IDLE before each start.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_dividend = '0;
  logic [W-1:0] i_divisor = '0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic         o_div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dd;
    int dv;
    int q;
    int r;
    int z;
    int t0;
    int lat;
    int busy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; between pulses results must hold.
  int           bcnt = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt   = 0;
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
    end else begin
      if (o_busy) bcnt++;
      if (o_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", o_quotient, e.q);
          chk("remainder", o_remainder, e.r);
          chk("div_by_zero", o_div_by_zero, e.z);
          chk("latency", cyc - e.t0, e.lat);
          chk("busy_cycles", bcnt, e.busy);
          if (e.dv != 0) begin
            chk("identity", int'(o_quotient) * e.dv + int'(o_remainder), e.dd);
            chk("rem_lt_div", (int'(o_remainder) < e.dv) ? 1 : 0, 1);
          end
        end
        bcnt   = 0;
        last_q = o_quotient;
        last_r = o_remainder;
        last_z = o_div_by_zero;
      end else begin
        chk("hold", {o_quotient, o_remainder, o_div_by_zero}, {last_q, last_r, last_z});
      end
    end
  end

  // Wait for IDLE, pulse start for one edge and record the reference result.
  task automatic issue(input int dd, input int dv);
    exp_t e;
    int   g;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while ((o_busy || o_done) && g < 60);
    if (g >= 60) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0d done=%0d want idle", o_busy, o_done);
    end
    i_dividend = W'(dd);
    i_divisor  = W'(dv);
    i_start    = 1'b1;
    e.dd = dd;
    e.dv = dv;
    if (dv == 0) begin
      e.q = (1 << W) - 1;
      e.r = dd;
      e.z = 1;
      e.lat = 0;
      e.busy = 0;
    end else begin
      e.q = dd / dv;
      e.r = dd % dv;
      e.z = 0;
      e.lat = W;
      e.busy = W;
    end
    e.t0 = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_quotient"}, o_quotient, 0);
    chk({tag, "_remainder"}, o_remainder, 0);
    chk({tag, "_dbz"}, o_div_by_zero, 0);
  endtask

  initial begin
    int dd;
    int dv;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst_n = 1'b1;

    issue(100, 7);
    drain();
    issue(255, 1);
    issue(255, 255);
    issue(3, 10);
    drain();
    issue(5, 0);
    issue(9, 4);
    drain();

    // Start and operand changes during RUN must not disturb the result.
    issue(200, 9);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    i_start    = 1'b1;
    i_dividend = 8'd1;
    i_divisor  = 8'd1;
    @(posedge clk);
    #1;
    i_start    = 1'b0;
    i_dividend = W'($urandom);
    i_divisor  = W'($urandom);
    drain();

    // Reset mid-RUN abandons the operation with no done pulse.
    issue(100, 7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk_cleared("midrun_reset");
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    issue(50, 5);
    drain();

    // Random sweep, each start issued as soon as the divider is back in IDLE.
    for (int i = 0; i < 2000; i++) begin
      if (i % 16 == 0) dv = (i % 32 == 0) ? 1 : 255;
      else             dv = int'($urandom_range(1, 255));
      dd = int'($urandom_range(0, 255));
      issue(dd, dv);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
